// File: rtl/fft_pkg.sv
// Shared constants, FSM state type and channel helper for the FFT frame arbiter slice.
package fft_pkg;
  localparam int unsigned DW        = 16;
  localparam int unsigned FFT_N     = 64;
  localparam int unsigned FRAME_LEN = 256;
  localparam int unsigned OUT_FIRST = 224;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_LOAD    = 2'd2,
    ST_COMPUTE = 2'd3
  } arb_state_e;

  function automatic logic [1:0] ch_onehot(input logic ch);
    return ch ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/fft_frame_arbiter_rr_arb2.sv
// Two-way round-robin pick: the pointed-to channel wins if requesting, else the other one.
module rr_arb2
  import fft_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic [1:0] grant_o,
  output logic       winner_o
);
  always_comb begin
    grant_o  = '0;
    winner_o = rr_ptr_i;
    if (!req_i[rr_ptr_i]) winner_o = ~rr_ptr_i;
    if (req_i != '0) grant_o = ch_onehot(winner_o);
  end
endmodule

// File: rtl/fft_frame_arbiter.sv
// Frame-granular round-robin scheduler sharing one 64-pt FFT core between two sources.
// Optional per-channel frame counters (frames0/frames1) under `FFT_ARB_STATS_EN.
module fft_frame_arbiter #(
  parameter int unsigned DW        = fft_pkg::DW,
  parameter int unsigned LOAD_LEN  = fft_pkg::FFT_N,
  parameter int unsigned FRAME_LEN = fft_pkg::FRAME_LEN,
  parameter int unsigned OUT_FIRST = fft_pkg::OUT_FIRST
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [1:0]    req,
  output logic [1:0]    gnt,
  input  logic [1:0]    s_valid,
  output logic [1:0]    s_ready,
  input  logic [DW-1:0] s_re0,
  input  logic [DW-1:0] s_im0,
  input  logic [DW-1:0] s_re1,
  input  logic [DW-1:0] s_im1,
  output logic          core_start,
  output logic          core_valid,
  output logic [DW-1:0] core_re,
  output logic [DW-1:0] core_im,
  output logic          busy,
  output logic          out_own,
  output logic          out_own_vld
`ifdef FFT_ARB_STATS_EN
  ,
  output logic [15:0]   frames0,
  output logic [15:0]   frames1
`endif
);
  import fft_pkg::*;

  localparam int unsigned CW = $clog2(FRAME_LEN);

  arb_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    gnt_q;
  logic          start_q, rr_q, owner_q, own_q, own_vld_q;
  logic [1:0]    arb_gnt;
  logic          arb_w;
  logic          in_load, accept, last_sample, frame_end, take;

  rr_arb2 u_rr_arb2 (
    .req_i    (req),
    .rr_ptr_i (rr_q),
    .grant_o  (arb_gnt),
    .winner_o (arb_w)
  );

  assign in_load     = (state_q == ST_LOAD);
  assign accept      = in_load && s_valid[owner_q];
  assign last_sample = accept && (cnt_q == CW'(LOAD_LEN - 1));
  assign frame_end   = (state_q == ST_COMPUTE) && (cnt_q == CW'(FRAME_LEN - 1));
  assign take        = (req != '0) && ((state_q == ST_IDLE) || frame_end);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      start_q   <= 1'b0;
      rr_q      <= 1'b0;
      owner_q   <= 1'b0;
      own_q     <= 1'b0;
      own_vld_q <= 1'b0;
    end else begin
      gnt_q     <= '0;
      start_q   <= 1'b0;
      own_vld_q <= (state_q == ST_COMPUTE) && (cnt_q >= CW'(OUT_FIRST));
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_ARB: state_q <= ST_LOAD;
        ST_LOAD: begin
          if (accept) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_sample) begin
              state_q <= ST_COMPUTE;
              own_q   <= owner_q;
            end
          end
        end
        ST_COMPUTE: begin
          cnt_q <= frame_end ? '0 : cnt_q + 1'b1;
          if (frame_end) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      // Grant from IDLE or straight out of a finished frame; overrides the IDLE fallback above.
      if (take) begin
        state_q <= ST_ARB;
        gnt_q   <= arb_gnt;
        start_q <= 1'b1;
        owner_q <= arb_w;
        rr_q    <= ~arb_w;
        cnt_q   <= '0;
      end
    end
  end

`ifdef FFT_ARB_STATS_EN
  logic [15:0] frames0_q, frames1_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      frames0_q <= '0;
      frames1_q <= '0;
    end else if (frame_end) begin
      if (owner_q) frames1_q <= frames1_q + 1'b1;
      else         frames0_q <= frames0_q + 1'b1;
    end
  end

  assign frames0 = frames0_q;
  assign frames1 = frames1_q;
`endif

  assign gnt         = gnt_q;
  assign core_start  = start_q;
  assign s_ready     = in_load ? ch_onehot(owner_q) : '0;
  assign core_valid  = in_load ? s_valid[owner_q] : (state_q == ST_COMPUTE);
  assign core_re     = in_load ? (owner_q ? s_re1 : s_re0) : '0;
  assign core_im     = in_load ? (owner_q ? s_im1 : s_im0) : '0;
  assign busy        = (state_q != ST_IDLE);
  assign out_own     = own_q;
  assign out_own_vld = own_vld_q;
endmodule
